// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI-slave-to-memory bridge.
// Holds the 2-bit command encodings sent at the start of every frame
// and the frame FSM state type.
package spi_mem_pkg;

  localparam int unsigned CMD_WIDTH = 2;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDUMMY,
    RDATA,
    DRAIN
  } state_e;

endpackage

// File: rtl/spi_mem_if.sv
// SPI pin bundle between the pad ring (master side) and the bridge (slave).
//   ss_n      : slave select, active low, frames a transaction
//   MOSI      : serial data into the bridge
//   MISO      : serial data out of the bridge, registered
//   frame_err : one-cycle pulse, frame aborted mid-field
//   addr_err  : one-cycle pulse, received address out of range
interface spi_mem_if;
  logic ss_n;
  logic MOSI;
  logic MISO;
  logic frame_err;
  logic addr_err;

  modport slave  (input ss_n, MOSI, output MISO, frame_err, addr_err);
  modport master (output ss_n, MOSI, input MISO, frame_err, addr_err);
endinterface

// File: rtl/spi_mem_array.sv
// DATA_WIDTH x MEM_DEPTH word store: synchronous write, asynchronous read.
// Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module spi_mem_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave bridge onto a word-addressed RAM. clk is the SCK domain: MOSI is
// sampled and MISO updated on the rising edge, MSB first. Each frame starts
// with a 2-bit command (write/read address, write/read data); with BURST_EN
// data frames stream consecutive words with pointer auto-increment.
//   clk   : system / SPI clock
//   rst_n : asynchronous active-low reset
//   spi   : SPI pins (ss_n, MOSI in; MISO, frame_err, addr_err out)
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter bit          BURST_EN   = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_mem_if.slave spi
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  // The last bit of a field is taken straight from MOSI, so only W-1 bits are stored.
  localparam int unsigned SH_W  = MAX_W - 1;
  localparam int unsigned CNT_W = $clog2(MAX_W) + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      ADDR_LAST_BIT = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                state;
  cmd_e                  cmd;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SH_W-1:0]       rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  cmd_e                  cmd_now;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] rd_ptr_inc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  we;

  always_comb begin
    cmd_now    = cmd_e'({rx_shift[0], spi.MOSI});
    rx_addr    = {rx_shift[ADDR_WIDTH-2:0], spi.MOSI};
    rx_word    = {rx_shift[DATA_WIDTH-2:0], spi.MOSI};
    addr_ok    = {1'b0, rx_addr} < DEPTH_EXT;
    wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
    rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
    // In RDATA the only array read that matters is the next burst word,
    // fetched on the same edge the pointer advances.
    rd_addr    = (state == RDATA) ? rd_ptr_inc : rd_ptr;
    we         = !spi.ss_n && (state == WDATA) && (bit_cnt == DATA_LAST_BIT);
  end

  spi_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(rx_word),
    .raddr(rd_addr),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd           <= CMD_WR_ADDR;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      spi.MISO      <= 1'b0;
      spi.frame_err <= 1'b0;
      spi.addr_err  <= 1'b0;
    end else begin
      spi.frame_err <= 1'b0;
      spi.addr_err  <= 1'b0;
      spi.MISO      <= 1'b0;
      if (spi.ss_n) begin
        // bit_cnt is zero exactly on field/word boundaries.
        if ((bit_cnt != '0) || (state == RDUMMY)) begin
          spi.frame_err <= 1'b1;
        end
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            rx_shift <= SH_W'(spi.MOSI);
            bit_cnt  <= CNT_W'(1);
            state    <= CMD;
          end
          CMD: begin
            cmd      <= cmd_now;
            bit_cnt  <= '0;
            rx_shift <= '0;
            case (cmd_now)
              CMD_WR_ADDR, CMD_RD_ADDR: state <= ADDR;
              CMD_WR_DATA:              state <= WDATA;
              default:                  state <= RDUMMY;
            endcase
          end
          ADDR: begin
            if (bit_cnt == ADDR_LAST_BIT) begin
              bit_cnt <= '0;
              state   <= DRAIN;
              if (addr_ok) begin
                if (cmd == CMD_RD_ADDR) rd_ptr <= rx_addr;
                else                    wr_ptr <= rx_addr;
              end else begin
                spi.addr_err <= 1'b1;
              end
            end else begin
              rx_shift <= (rx_shift << 1) | SH_W'(spi.MOSI);
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          WDATA: begin
            if (bit_cnt == DATA_LAST_BIT) begin
              bit_cnt <= '0;
              if (BURST_EN) wr_ptr <= wr_ptr_inc;
              else          state  <= DRAIN;
            end else begin
              rx_shift <= (rx_shift << 1) | SH_W'(spi.MOSI);
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          RDUMMY: begin
            spi.MISO <= rd_word[DATA_WIDTH-1];
            tx_shift <= rd_word << 1;
            bit_cnt  <= CNT_W'(1);
            state    <= RDATA;
          end
          RDATA: begin
            // bit_cnt counts bits already presented, modulo DATA_WIDTH;
            // zero means the previous word's LSB has just been shown.
            if (bit_cnt == '0) begin
              if (BURST_EN) begin
                rd_ptr   <= rd_ptr_inc;
                spi.MISO <= rd_word[DATA_WIDTH-1];
                tx_shift <= rd_word << 1;
                bit_cnt  <= CNT_W'(1);
              end else begin
                state <= DRAIN;
              end
            end else begin
              spi.MISO <= tx_shift[DATA_WIDTH-1];
              tx_shift <= tx_shift << 1;
              bit_cnt  <= (bit_cnt == DATA_LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
          end
          default: begin
            state <= DRAIN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge. Four instances cover the default
// build, single-word mode, a non-power-of-two depth and a wide 16/10 build.
// A behavioural memory/pointer model predicts every read and error pulse.
module tb_spi_mem_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ss_n_v = '1;
  logic [3:0] mosi_v = '0;
  logic [3:0] miso_v;
  logic [3:0] fe_v;
  logic [3:0] ae_v;

  int errors = 0;
  int checks = 0;

  int dw    [4] = '{8, 8, 8, 16};
  int aw    [4] = '{8, 8, 8, 10};
  int depth [4] = '{256, 256, 200, 1024};
  int burst [4] = '{1, 0, 1, 1};

  int fe_cnt [4] = '{0, 0, 0, 0};
  int ae_cnt [4] = '{0, 0, 0, 0};

  logic [31:0] mdl_mem [int];
  int wr_m [4] = '{0, 0, 0, 0};
  int rd_m [4] = '{0, 0, 0, 0};
  int last_wr [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  spi_mem_if bus0 ();
  spi_mem_if bus1 ();
  spi_mem_if bus2 ();
  spi_mem_if bus3 ();

  assign bus0.ss_n = ss_n_v[0];
  assign bus0.MOSI = mosi_v[0];
  assign bus1.ss_n = ss_n_v[1];
  assign bus1.MOSI = mosi_v[1];
  assign bus2.ss_n = ss_n_v[2];
  assign bus2.MOSI = mosi_v[2];
  assign bus3.ss_n = ss_n_v[3];
  assign bus3.MOSI = mosi_v[3];
  assign miso_v = {bus3.MISO, bus2.MISO, bus1.MISO, bus0.MISO};
  assign fe_v   = {bus3.frame_err, bus2.frame_err, bus1.frame_err, bus0.frame_err};
  assign ae_v   = {bus3.addr_err, bus2.addr_err, bus1.addr_err, bus0.addr_err};

  spi_mem_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .BURST_EN(1'b1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .spi(bus0));
  spi_mem_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .BURST_EN(1'b0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .spi(bus1));
  spi_mem_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .BURST_EN(1'b1))
    u_dut2 (.clk(clk), .rst_n(rst_n), .spi(bus2));
  spi_mem_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .BURST_EN(1'b1))
    u_dut3 (.clk(clk), .rst_n(rst_n), .spi(bus3));

  // Count error pulses away from the active edge; a stuck flag counts repeatedly.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fe_v[i]) fe_cnt[i]++;
      if (ae_v[i]) ae_cnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int key(input int d, input int a);
    return d * 65536 + a;
  endfunction

  function automatic logic [31:0] dmask(input int d);
    return (32'(1) << dw[d]) - 32'(1);
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic shift_out(input int d, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_v[d] = val[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cmd(input int d, input logic [1:0] c);
    ss_n_v[d] = 1'b0;
    shift_out(d, {30'd0, c}, 2);
  endtask

  task automatic end_frame(input int d);
    ss_n_v[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_addr(input int d, input bit rd, input int a, output int fe_d, output int ae_d);
    int fe0;
    int ae0;
    fe0 = fe_cnt[d];
    ae0 = ae_cnt[d];
    start_cmd(d, rd ? 2'b10 : 2'b00);
    shift_out(d, 32'(a), aw[d]);
    end_frame(d);
    if (a < depth[d]) begin
      if (rd) rd_m[d] = a;
      else    wr_m[d] = a;
    end
    fe_d = fe_cnt[d] - fe0;
    ae_d = ae_cnt[d] - ae0;
  endtask

  task automatic do_write(input int d, input int n, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2, output int fe_d);
    int fe0;
    logic [31:0] word;
    fe0 = fe_cnt[d];
    start_cmd(d, 2'b01);
    for (int k = 0; k < n; k++) begin
      word = ((k == 0) ? w0 : (k == 1) ? w1 : w2) & dmask(d);
      shift_out(d, word, dw[d]);
      if (burst[d] != 0 || k == 0) begin
        mdl_mem[key(d, wr_m[d])] = word;
        last_wr[d] = wr_m[d];
        if (burst[d] != 0) wr_m[d] = (wr_m[d] + 1) % depth[d];
      end
    end
    end_frame(d);
    fe_d = fe_cnt[d] - fe0;
  endtask

  // Reads nbits of MISO starting the cycle after the dummy; ends the frame on a word boundary.
  task automatic do_read(input int d, input int nbits, output logic [63:0] got, output int fe_d);
    int fe0;
    fe0 = fe_cnt[d];
    got = '0;
    start_cmd(d, 2'b11);
    mosi_v[d] = 1'($urandom);
    @(posedge clk);
    #1;
    for (int k = 0; k < nbits; k++) begin
      got = {got[62:0], miso_v[d]};
      if (k != nbits - 1) begin
        mosi_v[d] = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    end_frame(d);
    fe_d = fe_cnt[d] - fe0;
  endtask

  // Expected MISO stream for an nwords read frame from the model.
  task automatic model_read(input int d, input int nwords, output logic [63:0] want);
    logic [31:0] word;
    int a;
    want = '0;
    for (int w = 0; w < nwords; w++) begin
      if (burst[d] != 0 || w == 0) begin
        a = (burst[d] != 0) ? (rd_m[d] + w) % depth[d] : rd_m[d];
        word = mdl_mem.exists(key(d, a)) ? mdl_mem[key(d, a)] : 'x;
      end else begin
        word = '0;
      end
      want = (want << dw[d]) | 64'(word & dmask(d));
    end
    if (burst[d] != 0) rd_m[d] = (rd_m[d] + nwords - 1) % depth[d];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (miso_v[d] !== 1'b0) begin
        errors++; $display("FAIL reset_miso[%0d]: got %b expected 0", d, miso_v[d]);
      end
      checks++;
      if (fe_v[d] !== 1'b0) begin
        errors++; $display("FAIL reset_frame_err[%0d]: got %b expected 0", d, fe_v[d]);
      end
      checks++;
      if (ae_v[d] !== 1'b0) begin
        errors++; $display("FAIL reset_addr_err[%0d]: got %b expected 0", d, ae_v[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int fe_d, ae_d;
    logic [63:0] got, want;
    do_addr(0, 0, 'h10, fe_d, ae_d);
    do_write(0, 1, 32'hA5, 0, 0, fe_d);
    do_addr(0, 1, 'h10, fe_d, ae_d);
    do_read(0, 8, got, fe_d);
    model_read(0, 1, want);
    checks++;
    if (got !== want || got !== 64'hA5) begin
      errors++; $display("FAIL basic_read: got %h expected %h", got, want);
    end
    checks++;
    if (fe_d !== 0) begin
      errors++; $display("FAIL basic_read_frame_err: got %0d expected 0", fe_d);
    end
  endtask

  task automatic test_burst_wrap;
    int fe_d, ae_d;
    logic [63:0] got, want;
    do_addr(0, 0, 'hFF, fe_d, ae_d);
    do_write(0, 2, 32'h11, 32'h22, 0, fe_d);
    checks++;
    if (fe_d !== 0) begin
      errors++; $display("FAIL burst_write_frame_err: got %0d expected 0", fe_d);
    end
    do_addr(0, 1, 'hFF, fe_d, ae_d);
    do_read(0, 16, got, fe_d);
    model_read(0, 2, want);
    checks++;
    if (got !== want || got !== 64'h1122) begin
      errors++; $display("FAIL burst_wrap_read: got %h expected %h", got, want);
    end
    checks++;
    if (fe_d !== 0) begin
      errors++; $display("FAIL burst_read_boundary_frame_err: got %0d expected 0", fe_d);
    end
  endtask

  task automatic test_no_burst;
    int fe_d, ae_d, a;
    logic [63:0] got, want;
    a = $urandom_range(0, 254);
    do_addr(1, 0, a + 1, fe_d, ae_d);
    do_write(1, 1, 32'h5A, 0, 0, fe_d);
    do_addr(1, 0, a, fe_d, ae_d);
    do_write(1, 2, 32'h33, 32'h44, 0, fe_d);
    checks++;
    if (fe_d !== 0) begin
      errors++; $display("FAIL single_second_word_frame_err: got %0d expected 0", fe_d);
    end
    do_addr(1, 1, a, fe_d, ae_d);
    do_read(1, 16, got, fe_d);
    model_read(1, 2, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL single_read_then_zero: got %h expected %h", got, want);
    end
    do_addr(1, 1, a + 1, fe_d, ae_d);
    do_read(1, 8, got, fe_d);
    model_read(1, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL single_neighbour_untouched: got %h expected %h", got, want);
    end
    // Pointer must not have advanced: this write lands on a again.
    do_write(1, 1, 32'h77, 0, 0, fe_d);
    do_addr(1, 1, a, fe_d, ae_d);
    do_read(1, 8, got, fe_d);
    model_read(1, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL single_ptr_static: got %h expected %h", got, want);
    end
  endtask

  task automatic test_frame_abort;
    int fe_d, ae_d, fe0, a;
    logic [63:0] got, want;
    a = $urandom_range(0, 250);
    do_addr(0, 0, a, fe_d, ae_d);
    do_write(0, 2, 32'h3C, 32'hC3, 0, fe_d);
    do_addr(0, 0, a + 1, fe_d, ae_d);
    fe0 = fe_cnt[0];
    start_cmd(0, 2'b01);
    shift_out(0, $urandom, 5);
    end_frame(0);
    checks++;
    if (fe_cnt[0] - fe0 !== 1) begin
      errors++; $display("FAIL abort_data_frame_err: got %0d pulses expected 1", fe_cnt[0] - fe0);
    end
    do_addr(0, 1, a + 1, fe_d, ae_d);
    do_read(0, 8, got, fe_d);
    model_read(0, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL abort_word_unchanged: got %h expected %h", got, want);
    end
    do_write(0, 1, 32'h96, 0, 0, fe_d);
    do_addr(0, 1, a + 1, fe_d, ae_d);
    do_read(0, 8, got, fe_d);
    model_read(0, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL abort_ptr_unchanged: got %h expected %h", got, want);
    end
    // Abort after a single command bit.
    fe0 = fe_cnt[0];
    ss_n_v[0] = 1'b0;
    shift_out(0, 32'd1, 1);
    end_frame(0);
    checks++;
    if (fe_cnt[0] - fe0 !== 1) begin
      errors++; $display("FAIL abort_cmd_frame_err: got %0d pulses expected 1", fe_cnt[0] - fe0);
    end
    // Command complete, no data bits: a clean boundary.
    fe0 = fe_cnt[0];
    start_cmd(0, 2'b01);
    end_frame(0);
    checks++;
    if (fe_cnt[0] - fe0 !== 0) begin
      errors++; $display("FAIL empty_data_frame_err: got %0d pulses expected 0", fe_cnt[0] - fe0);
    end
  endtask

  task automatic test_addr_err;
    int fe_d, ae_d;
    logic [63:0] got, want;
    do_addr(2, 0, 'h20, fe_d, ae_d);
    checks++;
    if (ae_d !== 0) begin
      errors++; $display("FAIL addr_in_range_err: got %0d expected 0", ae_d);
    end
    do_addr(2, 0, 'hC8, fe_d, ae_d);
    checks++;
    if (ae_d !== 1) begin
      errors++; $display("FAIL addr_c8_err: got %0d pulses expected 1", ae_d);
    end
    checks++;
    if (fe_d !== 0) begin
      errors++; $display("FAIL addr_c8_frame_err: got %0d expected 0", fe_d);
    end
    do_write(2, 1, 32'h5E, 0, 0, fe_d);
    do_addr(2, 1, 'h20, fe_d, ae_d);
    do_read(2, 8, got, fe_d);
    model_read(2, 1, want);
    checks++;
    if (got !== want || got !== 64'h5E) begin
      errors++; $display("FAIL addr_err_old_ptr: got %h expected %h", got, want);
    end
    do_addr(2, 0, 199, fe_d, ae_d);
    checks++;
    if (ae_d !== 0) begin
      errors++; $display("FAIL addr_last_err: got %0d expected 0", ae_d);
    end
    do_addr(2, 1, 'hFF, fe_d, ae_d);
    checks++;
    if (ae_d !== 1) begin
      errors++; $display("FAIL rd_addr_ff_err: got %0d pulses expected 1", ae_d);
    end
    do_read(2, 8, got, fe_d);
    model_read(2, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL rd_addr_err_old_ptr: got %h expected %h", got, want);
    end
  endtask

  task automatic test_wide_reset;
    int fe_d, ae_d;
    logic [63:0] got, want;
    do_addr(3, 0, 'h3FF, fe_d, ae_d);
    do_write(3, 1, 32'hBEEF, 0, 0, fe_d);
    do_addr(3, 1, 'h3FF, fe_d, ae_d);
    do_read(3, 16, got, fe_d);
    model_read(3, 1, want);
    checks++;
    if (got !== want || got !== 64'hBEEF) begin
      errors++; $display("FAIL wide_read: got %h expected %h", got, want);
    end
    do_addr(3, 1, 'h3FF, fe_d, ae_d);
    start_cmd(3, 2'b11);
    @(posedge clk);
    #1;
    checks++;
    if (miso_v[3] !== 1'b1) begin
      errors++; $display("FAIL wide_first_bit: got %b expected 1", miso_v[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (miso_v[3] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_read_miso: got %b expected 0", miso_v[3]);
    end
    ss_n_v[3] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      wr_m[d] = 0;
      rd_m[d] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_addr(3, 1, 'h3FF, fe_d, ae_d);
    do_read(3, 16, got, fe_d);
    model_read(3, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL wide_kept_after_reset: got %h expected %h", got, want);
    end
    // No RD_ADDR since reset: reads from address 0.
    do_read(0, 8, got, fe_d);
    model_read(0, 1, want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL rd_ptr_zero_after_reset: got %h expected %h", got, want);
    end
    do_write(1, 1, 32'hC1, 0, 0, fe_d);
    do_addr(1, 1, 0, fe_d, ae_d);
    do_read(1, 8, got, fe_d);
    model_read(1, 1, want);
    checks++;
    if (got !== want || got !== 64'hC1) begin
      errors++; $display("FAIL wr_ptr_zero_after_reset: got %h expected %h", got, want);
    end
  endtask

  task automatic test_random;
    int fe_d, ae_d, op, a, n, exp_ae;
    logic [63:0] got, want;
    for (int d = 0; d < 4; d++) begin
      do_write(d, 1, $urandom, 0, 0, fe_d);
      for (int it = 0; it < 20; it++) begin
        op = $urandom_range(0, 2);
        if (op == 0) begin
          a = $urandom_range(0, (1 << aw[d]) - 1);
          exp_ae = (a >= depth[d]) ? 1 : 0;
          do_addr(d, 0, a, fe_d, ae_d);
          checks++;
          if (ae_d !== exp_ae) begin
            errors++; $display("FAIL rand_addr_err[%0d] a=%0h: got %0d expected %0d", d, a, ae_d, exp_ae);
          end
        end else if (op == 1) begin
          n = $urandom_range(1, 3);
          do_write(d, n, $urandom, $urandom, $urandom, fe_d);
          checks++;
          if (fe_d !== 0) begin
            errors++; $display("FAIL rand_write_frame_err[%0d]: got %0d expected 0", d, fe_d);
          end
        end else begin
          do_addr(d, 1, last_wr[d], fe_d, ae_d);
          do_read(d, dw[d], got, fe_d);
          model_read(d, 1, want);
          checks++;
          if (got !== want) begin
            errors++; $display("FAIL rand_read[%0d] a=%0h: got %h expected %h", d, last_wr[d], got, want);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst_wrap();
    test_no_burst();
    test_frame_abort();
    test_addr_err();
    test_random();
    test_wide_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
